// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: frames a sample stream into FFT_N-sample blocks for an FFT core and
// times the spectrum-energy accumulator and filtered-bin strobes off the core's output.
module fft_frame_ctrl #(
    parameter int FFT_N   = 256,
    parameter int MUL_LAT = 2,
    parameter int OUT_DLY = 260
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        din_valid,
    input  logic [15:0] din,
    input  logic        sink_ready,
    output logic        sink_valid,
    output logic        sink_sop,
    output logic        sink_eop,
    output logic [15:0] sink_real,
    input  logic        source_valid,
    input  logic        source_sop,
    input  logic        source_eop,
    output logic        acc_clr,
    output logic        acc_en,
    output logic        gate_load,
    output logic        out_valid,
    output logic        out_sop,
    output logic [15:0] in_frames,
    output logic [15:0] out_frames,
    output logic        overrun,
    output logic        frame_err
);
    localparam int CW = $clog2(FFT_N);
    localparam logic [CW-1:0] LAST = CW'(FFT_N - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
    state_t state, state_nx;

    logic              full, xfer, last, cap;
    logic [15:0]       hold;
    logic [CW-1:0]     cnt, bin, bin_cur;
    logic              sop_beat, eop_beat, in_flight, last_eop;
    logic [MUL_LAT-1:0] clr_d, accen_d;
    logic [MUL_LAT:0]   gate_d;
    logic [OUT_DLY-1:0] ov_d, os_d;

    assign xfer     = full & sink_ready;
    assign last     = cnt == LAST;
    // the sample arriving alongside the final transfer of a stopping frame is not kept
    assign cap      = (state == LOAD) & din_valid & (~full | xfer) & ~(xfer & last & ~en);
    assign sop_beat = source_valid & source_sop;
    assign eop_beat = source_valid & source_eop;
    assign bin_cur  = source_sop ? '0 : bin;

    assign sink_valid = full;
    assign sink_real  = hold;
    assign sink_sop   = full & (cnt == '0);
    assign sink_eop   = full & last;
    assign acc_clr    = clr_d[MUL_LAT-1];
    assign acc_en     = accen_d[MUL_LAT-1];
    assign gate_load  = gate_d[MUL_LAT];
    assign out_valid  = ov_d[OUT_DLY-1];
    assign out_sop    = os_d[OUT_DLY-1];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = en ? LOAD : IDLE;
            LOAD:    state_nx = (xfer && last && !en) ? DRAIN : LOAD;
            DRAIN:   state_nx = (bin == '0 && !in_flight) ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            full       <= 1'b0;
            hold       <= '0;
            cnt        <= '0;
            in_frames  <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            full       <= cap ? 1'b1 : xfer ? 1'b0 : full;
            hold       <= cap ? din : hold;
            cnt        <= (state == IDLE) ? '0 : xfer ? cnt + 1'b1 : cnt;
            in_frames  <= in_frames + 16'(xfer & last);
            overrun    <= overrun | ((state == LOAD) & din_valid & full & ~xfer);
        end
    end

    // bin holds the index expected for the next source beat, so it wraps to 0 after a full frame
    always_ff @(posedge clk) begin
        if (rst) begin
            bin        <= '0;
            in_flight  <= 1'b0;
            last_eop   <= 1'b0;
            out_frames <= '0;
            frame_err  <= 1'b0;
            clr_d      <= '0;
            accen_d    <= '0;
            gate_d     <= '0;
            ov_d       <= '0;
            os_d       <= '0;
        end else begin
            if (source_valid) begin
                bin       <= bin_cur + 1'b1;
                last_eop  <= source_eop;
                in_flight <= source_eop ? 1'b0 : source_sop ? 1'b1 : in_flight;
            end
            out_frames <= out_frames + 16'(eop_beat);
            frame_err  <= frame_err | (eop_beat & (bin_cur != LAST))
                                    | (sop_beat & (bin != '0) & ~last_eop);
            clr_d      <= (clr_d << 1) | MUL_LAT'(sop_beat);
            accen_d    <= (accen_d << 1) | MUL_LAT'(source_valid);
            gate_d     <= (gate_d << 1) | (MUL_LAT + 1)'(eop_beat);
            ov_d       <= (ov_d << 1) | OUT_DLY'(source_valid);
            os_d       <= (os_d << 1) | OUT_DLY'(sop_beat);
        end
    end
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: directed sequences, a frame-error vector table and a randomized run
// checked against a queue/history-array model of fft_frame_ctrl.
module tb_fft_frame_ctrl;
    localparam int N  = 256;
    localparam int ML = 2;
    localparam int OD = 260;

    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, din_valid = 1'b0, sink_ready = 1'b0;
    logic [15:0] din = '0;
    logic        source_valid = 1'b0, source_sop = 1'b0, source_eop = 1'b0;
    logic        sink_valid, sink_sop, sink_eop, acc_clr, acc_en, gate_load, out_valid, out_sop;
    logic        overrun, frame_err;
    logic [15:0] sink_real, in_frames, out_frames;

    fft_frame_ctrl #(.FFT_N(N), .MUL_LAT(ML), .OUT_DLY(OD)) dut (
        .clk(clk), .rst(rst), .en(en), .din_valid(din_valid), .din(din),
        .sink_ready(sink_ready), .sink_valid(sink_valid), .sink_sop(sink_sop),
        .sink_eop(sink_eop), .sink_real(sink_real), .source_valid(source_valid),
        .source_sop(source_sop), .source_eop(source_eop), .acc_clr(acc_clr),
        .acc_en(acc_en), .gate_load(gate_load), .out_valid(out_valid), .out_sop(out_sop),
        .in_frames(in_frames), .out_frames(out_frames), .overrun(overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, n = 0;
    int f_xfers, f_sop_idx, f_sop_val, f_eop_idx, f_eop_val, f_order_bad, f_after_eop, f_hold_bad;
    bit beat_h[2048], sop_h[2048], eop_h[2048];

    typedef struct {
        int len;
        bit eop_last;
        bit extra_sop;
        bit exp_err;
        int exp_of;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("reset_outputs_zero", {sink_valid, sink_sop, sink_eop, sink_real, acc_clr, acc_en,
            gate_load, out_valid, out_sop, in_frames, out_frames, overrun, frame_err}, 0);
        {en, din_valid, sink_ready, source_valid, source_sop, source_eop} = '0;
        din = '0;
        rst = 1'b0;
        n = 0;
    endtask

    task automatic start_frames();
        en = 1'b1;
        din_valid = 1'b0;
        tick();
    endtask

    // offers din=n every cycle; ready drops for 3 cycles at rlo_at; en drops once n reaches en_drop
    task automatic feed(input int ncyc, input int rlo_at, input int en_drop);
        int prev;
        logic [15:0] held;
        prev = -1; held = '0;
        f_xfers = 0; f_sop_idx = -1; f_sop_val = -1; f_eop_idx = -1; f_eop_val = -1;
        f_order_bad = 0; f_after_eop = 0; f_hold_bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            sink_ready = !(rlo_at >= 0 && i >= rlo_at && i < rlo_at + 3);
            en = (en_drop < 0) || (n < en_drop);
            din_valid = 1'b1;
            din = 16'(n);
            if (!sink_ready) begin
                if (!sink_valid || (i > rlo_at && sink_real != held)) f_hold_bad++;
                held = sink_real;
            end
            if (en_drop >= 0 && f_eop_idx >= 0 && sink_valid) f_after_eop++;
            if (sink_valid && sink_ready) begin
                if (int'(sink_real) <= prev) f_order_bad++;
                prev = int'(sink_real);
                if (sink_sop && f_sop_idx < 0) begin f_sop_idx = f_xfers; f_sop_val = int'(sink_real); end
                if (sink_eop && f_eop_idx < 0) begin f_eop_idx = f_xfers; f_eop_val = int'(sink_real); end
                f_xfers++;
            end
            n++;
            tick();
        end
    endtask

    function automatic bit hb(input int k); return k >= 0 ? beat_h[k] : 1'b0; endfunction
    function automatic bit hs(input int k); return k >= 0 ? sop_h[k]  : 1'b0; endfunction
    function automatic bit he(input int k); return k >= 0 ? eop_h[k]  : 1'b0; endfunction

    initial begin
        int n0;
        tbl[0] = '{len: 256, eop_last: 1'b1, extra_sop: 1'b0, exp_err: 1'b0, exp_of: 1};
        tbl[1] = '{len: 201, eop_last: 1'b1, extra_sop: 1'b0, exp_err: 1'b1, exp_of: 1};
        tbl[2] = '{len: 100, eop_last: 1'b0, extra_sop: 1'b1, exp_err: 1'b1, exp_of: 0};
        tbl[3] = '{len: 256, eop_last: 1'b1, extra_sop: 1'b1, exp_err: 1'b0, exp_of: 1};
        tbl[4] = '{len: 1,   eop_last: 1'b1, extra_sop: 1'b0, exp_err: 1'b1, exp_of: 1};

        tick();
        do_reset();

        // continuous stream, then a 3-cycle ready stall
        start_frames();
        feed(300, -1, -1);
        chk("a_sop_idx", f_sop_idx, 0);
        chk("a_sop_val", f_sop_val, 0);
        chk("a_eop_idx", f_eop_idx, 255);
        chk("a_eop_val", f_eop_val, 255);
        chk("a_order", f_order_bad, 0);
        chk("a_in_frames", in_frames, 1);
        chk("a_overrun", overrun, 0);
        feed(40, 10, -1);
        chk("stall_hold", f_hold_bad, 0);
        chk("stall_overrun", overrun, 1);
        chk("stall_order", f_order_bad, 0);
        chk("stall_xfers", f_xfers, 37);

        // en dropped mid-frame
        do_reset();
        start_frames();
        feed(400, -1, 100);
        chk("drop_xfers", f_xfers, 256);
        chk("drop_eop_idx", f_eop_idx, 255);
        chk("drop_eop_val", f_eop_val, 255);
        chk("drop_valid_after", f_after_eop, 0);
        chk("drop_in_frames", in_frames, 1);
        start_frames();
        n0 = n;
        feed(20, -1, -1);
        chk("restart_sop_idx", f_sop_idx, 0);
        chk("restart_sop_val", f_sop_val, n0);

        // reset in the middle of a frame
        do_reset();
        start_frames();
        feed(51, -1, -1);
        do_reset();
        start_frames();
        feed(10, -1, -1);
        chk("rst_mid_sop_idx", f_sop_idx, 0);
        chk("rst_mid_sop_val", f_sop_val, 0);
        chk("rst_mid_in_frames", in_frames, 0);

        // one clean source frame: event timing
        do_reset();
        begin
            int clr_first = -1, clr_cnt = 0, ae_first = -1, ae_cnt = 0, gl_first = -1;
            int os_first = -1, ov_first = -1, ov_cnt = 0;
            for (int c = 0; c < 600; c++) begin
                if (acc_clr) begin clr_cnt++; if (clr_first < 0) clr_first = c; end
                if (acc_en) begin ae_cnt++; if (ae_first < 0) ae_first = c; end
                if (gate_load && gl_first < 0) gl_first = c;
                if (out_sop && os_first < 0) os_first = c;
                if (out_valid) begin ov_cnt++; if (ov_first < 0) ov_first = c; end
                source_valid = c < N;
                source_sop = c == 0;
                source_eop = c == N - 1;
                tick();
            end
            {source_valid, source_sop, source_eop} = '0;
            chk("src_acc_clr_at", clr_first, ML);
            chk("src_acc_clr_cnt", clr_cnt, 1);
            chk("src_acc_en_at", ae_first, ML);
            chk("src_acc_en_cnt", ae_cnt, N);
            chk("src_gate_load_at", gl_first, N - 1 + ML + 1);
            chk("src_out_sop_at", os_first, OD);
            chk("src_out_valid_at", ov_first, OD);
            chk("src_out_valid_cnt", ov_cnt, N);
            chk("src_out_frames", out_frames, 1);
            chk("src_frame_err", frame_err, 0);
        end

        // frame-error vector table
        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < tbl[v].len; i++) begin
                source_valid = 1'b1;
                source_sop = i == 0;
                source_eop = tbl[v].eop_last && i == tbl[v].len - 1;
                tick();
            end
            if (tbl[v].extra_sop) begin
                {source_valid, source_sop, source_eop} = 3'b110;
                tick();
            end
            {source_valid, source_sop, source_eop} = '0;
            repeat (3) tick();
            chk($sformatf("tbl%0d_frame_err", v), frame_err, tbl[v].exp_err);
            chk($sformatf("tbl%0d_out_frames", v), out_frames, tbl[v].exp_of);
            repeat (5) tick();
            chk($sformatf("tbl%0d_err_sticky", v), frame_err, tbl[v].exp_err);
        end

        // randomized run: input side against a sample queue, output side against beat history
        do_reset();
        start_frames();
        begin
            logic [15:0] q[$];
            int xf = 0, eops = 0, src_i = 0;
            bit ov_m = 0;
            for (int c = 0; c < 2000; c++) begin
                chk("r_sink_valid", sink_valid, q.size() != 0);
                if (q.size() != 0) chk("r_sink_real", sink_real, q[0]);
                chk("r_sink_sop", sink_sop, q.size() != 0 && xf % N == 0);
                chk("r_sink_eop", sink_eop, q.size() != 0 && xf % N == N - 1);
                chk("r_overrun", overrun, ov_m);
                chk("r_in_frames", in_frames, 16'(xf / N));
                chk("r_acc_clr", acc_clr, hs(c - ML));
                chk("r_acc_en", acc_en, hb(c - ML));
                chk("r_gate_load", gate_load, he(c - ML - 1));
                chk("r_out_valid", out_valid, hb(c - OD));
                chk("r_out_sop", out_sop, hs(c - OD));
                chk("r_out_frames", out_frames, 16'(eops));
                chk("r_frame_err", frame_err, 0);
                sink_ready = $urandom_range(3) != 0;
                din_valid = $urandom_range(9) < 7;
                din = 16'($urandom);
                source_valid = ((c < 1500) || src_i != 0) && ($urandom_range(3) != 0);
                source_sop = source_valid && src_i == 0;
                source_eop = source_valid && src_i == N - 1;
                beat_h[c] = source_valid;
                sop_h[c] = source_sop;
                eop_h[c] = source_eop;
                if (source_valid) src_i = (src_i + 1) % N;
                if (source_eop) eops++;
                if (q.size() != 0 && sink_ready) begin
                    void'(q.pop_front());
                    xf++;
                end
                if (din_valid) begin
                    if (q.size() == 0) q.push_back(din);
                    else ov_m = 1;
                end
                tick();
            end
        end
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter FFT_N, default 256: FFT frame length in samples (power of two, 8..4096).
REQ-002 Parameter MUL_LAT, default 2: latency of the downstream squaring multipliers, in cycles.
REQ-003 Parameter OUT_DLY, default 260: source beat to filtered output valid delay (FFT_N + MUL_LAT + 2).
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 en  in  1  level; 1 = keep issuing frames, 0 = stop after the current frame.
REQ-007 din_valid  in  1  input sample strobe.
REQ-008 din  in  16  signed input sample.
REQ-009 sink_ready  in  1  FFT core ready.
REQ-010 sink_valid / sink_sop / sink_eop  out  1 each  FFT sink handshake.
REQ-011 sink_real  out  16  sample presented to the FFT core.
REQ-012 source_valid / source_sop / source_eop  in  1 each  FFT source handshake; source_ready is tied high externally.
REQ-013 acc_clr / acc_en  out  1 each  spectrum-energy accumulator clear-and-load / accumulate strobes.
REQ-014 gate_load  out  1  one-cycle pulse: accumulator holds the complete frame sum.
REQ-015 out_valid / out_sop  out  1 each  filtered-bin output strobes.
REQ-016 in_frames / out_frames  out  16  frames sent to / received from the core.
REQ-017 overrun / frame_err  out  1 each  sticky error flags.

Function
REQ-018 Input FSM states: IDLE, LOAD, DRAIN. A transfer occurs on a cycle with sink_valid=1 and sink_ready=1.
REQ-019 IDLE -> LOAD when en=1; the sample counter is cleared to 0 on entry.
REQ-020 In LOAD, din is captured into a 1-deep holding register; sink_valid=1 while the register is full; the register is freed on a transfer.
REQ-021 If din_valid=1, the register is full, and no transfer occurs in that cycle, the sample is dropped and overrun sets.
REQ-022 If din_valid=1 in the same cycle the register is freed, the new sample is accepted with no bubble.
REQ-023 sink_sop=1 on the transfer with count 0; sink_eop=1 on the transfer with count FFT_N-1; the counter increments per transfer and wraps to 0 after FFT_N-1.
REQ-024 After the eop transfer: if en=1, remain in LOAD (next frame); else go to DRAIN. in_frames increments by 1 on each eop transfer and wraps at 16 bits.
REQ-025 en=0 mid-frame does not truncate the frame; the frame completes to FFT_N samples.
REQ-026 DRAIN returns to IDLE on the first cycle with no source beat outstanding (bin counter = 0 and no frame in flight).
REQ-027 A source beat is a cycle with source_valid=1. The bin counter clears on a source_sop beat and increments on every other beat.
REQ-028 acc_clr = (beat & source_sop) delayed exactly MUL_LAT cycles.
REQ-029 acc_en = beat delayed exactly MUL_LAT cycles.
REQ-030 gate_load = (beat & source_eop) delayed MUL_LAT+1 cycles.
REQ-031 out_valid = beat delayed exactly OUT_DLY cycles, implemented as a shift line; out_sop = (beat & source_sop) delayed OUT_DLY cycles.
REQ-032 out_frames increments by 1 on each source_eop beat and wraps at 16 bits.
REQ-033 frame_err sets if source_eop arrives with bin count != FFT_N-1.
REQ-034 frame_err sets if source_sop arrives while the bin count is not 0 and the previous beat was not an eop.
REQ-035 overrun and frame_err clear only on rst.

Reset
REQ-036 On rst=1 at a clock edge: FSM enters IDLE; counters, holding register, and delay lines clear.
REQ-037 Every output is 0 in the cycle after the rst edge, including in_frames, out_frames, and the error flags.
REQ-038 rst mid-frame abandons the partial frame; no sink_eop is issued for it.
REQ-039 After rst, the first frame starts with count 0 and sink_sop.

Verification
REQ-040 en=1, sink_ready=1, din_valid every cycle, din=n -> sop on din=0, eop on din=255, in_frames=1 after 256 transfers, overrun=0.
REQ-041 sink_ready low for 3 cycles mid-frame with continuous din_valid -> sink_valid held, overrun=1, later transfers continue in order.
REQ-042 en dropped at sample 100 -> frame still ends at sample 255 with eop; FSM reaches IDLE; no further sink_valid.
REQ-043 256-beat source frame with sop/eop -> acc_clr at beat0+2, acc_en for 256 cycles, gate_load at eop+3, out_sop at sop+260, 256 out_valid cycles, out_frames=1.
REQ-044 source_eop on bin 200 -> frame_err=1 and held until rst.
REQ-045 rst asserted at sample 50 of a frame -> all outputs 0 next cycle; the next frame begins at count 0 with sink_sop.
